// File: rtl/rr_unit_scheduler.sv
// Round-robin scheduler sharing one multi-cycle arithmetic unit among
// N_REQ requesters; one transaction in flight, results tagged by index.
module rr_unit_scheduler #(
   parameter  int N_REQ  = 8,
   parameter  int DATA_W = 16,
   localparam int ID_W   = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic                    svc_valid,
   input  logic                    svc_ready,
   output logic [DATA_W-1:0]       svc_data,
   output logic [ID_W-1:0]         svc_id,
   input  logic                    rsp_valid,
   input  logic [DATA_W-1:0]       rsp_data,
   output logic [N_REQ-1:0]        done,
   output logic [DATA_W-1:0]       done_data,
   output logic                    busy,
   output logic                    err_stray
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [N_REQ-1:0] masked;
   logic            m_hit;
   logic [ID_W-1:0] m_idx;
   logic [ID_W-1:0] u_idx;
   logic [ID_W-1:0] winner;
   logic [ID_W-1:0] ptr_next;

   // Two descending scans so the lowest set index wins each chain.
   always_comb begin
      masked = '0;
      m_hit  = 1'b0;
      m_idx  = '0;
      u_idx  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         masked[i] = req[i] && (ID_W'(i) >= ptr);
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            u_idx = ID_W'(i);
         end
         if (masked[i]) begin
            m_hit = 1'b1;
            m_idx = ID_W'(i);
         end
      end
   end

   assign winner   = m_hit ? m_idx : u_idx;
   assign ptr_next = (svc_id == ID_W'(N_REQ - 1)) ? '0 : svc_id + ID_W'(1);

   // svc_valid is only high in ISSUE, so this is the handshake cycle.
   always_comb begin
      ack = '0;
      if (svc_valid && svc_ready) begin
         ack[svc_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         svc_valid <= 1'b0;
         svc_data  <= '0;
         svc_id    <= '0;
         done      <= '0;
         done_data <= '0;
         busy      <= 1'b0;
         err_stray <= 1'b0;
      end else begin
         done <= '0;
         if (rsp_valid && state != S_WAIT) begin
            err_stray <= 1'b1;
         end
         unique case (state)
            S_IDLE: begin
               if (|req) begin
                  svc_id    <= winner;
                  svc_data  <= req_data[int'(winner)*DATA_W +: DATA_W];
                  svc_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (svc_ready) begin
                  svc_valid <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (rsp_valid) begin
                  done[svc_id] <= 1'b1;
                  done_data    <= rsp_data;
                  ptr          <= ptr_next;
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_unit_scheduler.sv
// Bench for rr_unit_scheduler: table of grants plus hand sequences,
// with a queue of expected results checked whenever done pulses.
module tb_rr_unit_scheduler;

   logic         clk;
   logic         rst;
   logic [7:0]   req;
   logic [127:0] req_data;
   logic [7:0]   ack;
   logic         svc_valid;
   logic         svc_ready;
   logic [15:0]  svc_data;
   logic [2:0]   svc_id;
   logic         rsp_valid;
   logic [15:0]  rsp_data;
   logic [7:0]   done;
   logic [15:0]  done_data;
   logic         busy;
   logic         err_stray;

   logic [15:0]  dv [8];

   typedef struct {
      logic [7:0] oh;
      logic [15:0] d;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [7:0] r;
      logic [2:0] id;
      int         rdy;
      int         lat;
   } vec_t;
   vec_t tbl[15];

   int checks = 0;
   int errors = 0;

   rr_unit_scheduler dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .ack(ack), .svc_valid(svc_valid), .svc_ready(svc_ready),
      .svc_data(svc_data), .svc_id(svc_id), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .done(done), .done_data(done_data),
      .busy(busy), .err_stray(err_stray)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         req_data[i*16 +: 16] = dv[i];
      end
   end

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && done !== 8'h00) begin
         if (sb.size() == 0) begin
            chk("done_unexpected", {24'h0, done}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_done", {24'h0, done}, {24'h0, e.oh});
            chk("sb_data", {16'h0, done_data}, {16'h0, e.d});
         end
      end
      if (!rst && ack !== 8'h00) begin
         chk("ack_done_overlap", {24'h0, done}, 32'h0);
      end
   end

   task automatic txn(input logic [7:0] r, input logic [2:0] id,
                      input int rdy, input int lat, input bit drop);
      logic [15:0] d;
      logic [7:0]  oh;
      d  = dv[id];
      oh = 8'h01 << id;
      @(posedge clk);
      #1 req = r;
      @(posedge clk);
      @(negedge clk);
      chk("grant_valid", {31'h0, svc_valid}, 32'h1);
      chk("grant_id", {29'h0, svc_id}, {29'h0, id});
      chk("grant_data", {16'h0, svc_data}, {16'h0, d});
      chk("busy_issue", {31'h0, busy}, 32'h1);
      if (drop) begin
         req    = 8'h00;
         dv[id] = ~d;
      end
      for (int k = 0; k < rdy; k++) begin
         chk("bp_noack", {24'h0, ack}, 32'h0);
         @(negedge clk);
         chk("bp_valid", {31'h0, svc_valid}, 32'h1);
         chk("bp_id", {29'h0, svc_id}, {29'h0, id});
         chk("bp_data", {16'h0, svc_data}, {16'h0, d});
      end
      svc_ready = 1'b1;
      #1;
      chk("ack", {24'h0, ack}, {24'h0, oh});
      @(negedge clk);
      svc_ready = 1'b0;
      req       = 8'h00;
      chk("wait_novalid", {31'h0, svc_valid}, 32'h0);
      chk("wait_busy", {31'h0, busy}, 32'h1);
      for (int k = 1; k < lat; k++) begin
         @(negedge clk);
         chk("wait_nodone", {24'h0, done}, 32'h0);
      end
      rsp_valid = 1'b1;
      rsp_data  = d ^ 16'h5A5A;
      sb.push_back('{oh: oh, d: d ^ 16'h5A5A});
      @(negedge clk);
      rsp_valid = 1'b0;
      chk("done_time", {24'h0, done}, {24'h0, oh});
      chk("busy_idle", {31'h0, busy}, 32'h0);
   endtask

   task automatic chk_reset(input string n);
      chk({n, "_valid"}, {31'h0, svc_valid}, 32'h0);
      chk({n, "_busy"}, {31'h0, busy}, 32'h0);
      chk({n, "_id"}, {29'h0, svc_id}, 32'h0);
      chk({n, "_data"}, {16'h0, svc_data}, 32'h0);
      chk({n, "_ack"}, {24'h0, ack}, 32'h0);
      chk({n, "_done"}, {24'h0, done}, 32'h0);
      chk({n, "_err"}, {31'h0, err_stray}, 32'h0);
   endtask

   initial begin
      tbl[0]  = '{8'hFF, 3'd0, 0, 1};
      tbl[1]  = '{8'hFF, 3'd1, 0, 1};
      tbl[2]  = '{8'hFF, 3'd2, 1, 2};
      tbl[3]  = '{8'hFF, 3'd3, 0, 1};
      tbl[4]  = '{8'hFF, 3'd4, 0, 3};
      tbl[5]  = '{8'hFF, 3'd5, 0, 1};
      tbl[6]  = '{8'hFF, 3'd6, 2, 1};
      tbl[7]  = '{8'hFF, 3'd7, 0, 1};
      tbl[8]  = '{8'hFF, 3'd0, 0, 1};
      tbl[9]  = '{8'h04, 3'd2, 0, 1};
      tbl[10] = '{8'h02, 3'd1, 0, 2};
      tbl[11] = '{8'h20, 3'd5, 0, 1};
      tbl[12] = '{8'h21, 3'd0, 0, 1};
      tbl[13] = '{8'h21, 3'd5, 1, 1};
      tbl[14] = '{8'h80, 3'd7, 0, 1};
      for (int i = 0; i < 8; i++) begin
         dv[i] = 16'hA0A0 + 16'(i) * 16'h0111;
      end
      dv[2]     = 16'h1234;
      rst       = 1'b1;
      req       = 8'h00;
      svc_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = 16'h0;
      @(negedge clk);
      chk_reset("reset");
      chk("reset_ddata", {16'h0, done_data}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Stray response while idle sets a sticky flag and no done.
      rsp_valid = 1'b1;
      rsp_data  = 16'hDEAD;
      @(negedge clk);
      rsp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("stray_err", {31'h0, err_stray}, 32'h1);
         chk("stray_nodone", {24'h0, done}, 32'h0);
         @(negedge clk);
      end

      // Abort a transaction with reset while waiting for the unit.
      @(posedge clk);
      #1 req = 8'h10;
      @(posedge clk);
      @(negedge clk);
      svc_ready = 1'b1;
      #1;
      chk("abort_ack", {24'h0, ack}, 32'h10);
      @(negedge clk);
      svc_ready = 1'b0;
      req       = 8'h00;
      chk("abort_busy", {31'h0, busy}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk_reset("async_rst");
      rsp_valid = 1'b1;
      @(negedge clk);
      rsp_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_nodone", {24'h0, done}, 32'h0);
         chk("abort_noerr", {31'h0, err_stray}, 32'h0);
      end

      for (int i = 0; i < 15; i++) begin
         txn(tbl[i].r, tbl[i].id, tbl[i].rdy, tbl[i].lat, 1'b0);
      end

      // Single request from ptr=0.
      txn(8'h04, 3'd2, 0, 1, 1'b0);
      // Five cycles of backpressure.
      txn(8'h08, 3'd3, 5, 1, 1'b0);
      // Requester drops req and changes data after the grant.
      txn(8'h40, 3'd6, 2, 1, 1'b1);
      txn(8'h40, 3'd6, 0, 1, 1'b0);

      repeat (3) @(negedge clk);
      chk("final_noerr", {31'h0, err_stray}, 32'h0);
      chk("sb_empty", sb.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
